// File: rtl/csm_port_if.sv
// Processor-side port of the CSM arbiter: multiplexed address/data bus with
// access, hold and release requests, plus the ack/err/read-data response.
interface csm_port_if #(parameter int DATA_W = 8);
   logic [DATA_W-1:0] in_ad;
   logic              rw;
   logic              enable;
   logic              hold;
   logic              release_lock;
   logic              ack;
   logic [1:0]        err;
   logic [DATA_W-1:0] out_data;

   modport master (output in_ad, rw, enable, hold, release_lock,
                   input  ack, err, out_data);
   modport slave  (input  in_ad, rw, enable, hold, release_lock,
                   output ack, err, out_data);
endinterface

// File: rtl/csm_port_arbiter.sv
// Two-port sequencer in front of the single-ported CSM register file:
// per-port protocol FSMs, round-robin memory arbitration and a hold-lock table.
//
// state | meaning
// IDLE  | waiting for enable / hold / release
// WDATA | address latched, capturing write data from in_ad
// REQ   | requesting the memory (or lock-denied)
// RESP  | one-cycle ack with err
module csm_port_arbiter #(
   parameter int NUM_REGS = 4,
   parameter int ADDR_W   = 2,
   parameter int DATA_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   csm_port_if.slave         port_a,
   csm_port_if.slave         port_b,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, WDATA, REQ, RESP} state_t;
   localparam logic [1:0] FREE = 2'd0;

   function automatic logic [1:0] own_code(input int p);
      return 2'(p + 1);
   endfunction

   logic [DATA_W-1:0] p_ad [2];
   logic              p_rw [2], p_en [2], p_hold [2], p_rel [2];

   assign p_ad[0]   = port_a.in_ad;        assign p_ad[1]   = port_b.in_ad;
   assign p_rw[0]   = port_a.rw;           assign p_rw[1]   = port_b.rw;
   assign p_en[0]   = port_a.enable;       assign p_en[1]   = port_b.enable;
   assign p_hold[0] = port_a.hold;         assign p_hold[1] = port_b.hold;
   assign p_rel[0]  = port_a.release_lock; assign p_rel[1]  = port_b.release_lock;

   state_t            state_q [2], state_d [2];
   logic [ADDR_W-1:0] addr_q  [2], addr_d  [2];
   logic              rw_q    [2], rw_d    [2];
   logic [DATA_W-1:0] wdata_q [2], wdata_d [2];
   logic [DATA_W-1:0] rdata_q [2], rdata_d [2];
   logic              ack_q   [2], ack_d   [2];
   logic [1:0]        err_q   [2], err_d   [2];
   logic [1:0]        lock_q  [NUM_REGS], lock_d [NUM_REGS];
   logic              last_q, last_d;   // 0 = A granted last, 1 = B

   logic [ADDR_W-1:0] in_addr [2];
   logic              acc_ok [2], req [2], grant [2], hold_only [2], multi [2];
   logic              hold_tie, sel;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         in_addr[p]   = p_ad[p][ADDR_W-1:0];
         acc_ok[p]    = (lock_q[addr_q[p]] == FREE) || (lock_q[addr_q[p]] == own_code(p));
         req[p]       = (state_q[p] == REQ) && acc_ok[p];
         multi[p]     = (p_en[p] & p_hold[p]) | (p_en[p] & p_rel[p]) | (p_hold[p] & p_rel[p]);
         hold_only[p] = (state_q[p] == IDLE) && p_hold[p] && !p_en[p] && !p_rel[p];
      end
      grant[0] = req[0] && (!req[1] || last_q);
      grant[1] = req[1] && (!req[0] || !last_q);
      hold_tie = hold_only[0] && hold_only[1] && (in_addr[0] == in_addr[1]) &&
                 (lock_q[in_addr[0]] == FREE);
   end

   // Memory strobe is combinational from the REQ-cycle grant; gated so a
   // reset landing on a REQ cycle can never write.
   assign sel       = grant[1];
   assign mem_en    = (grant[0] | grant[1]) & ~reset;
   assign mem_we    = mem_en & rw_q[sel];
   assign mem_addr  = addr_q[sel];
   assign mem_wdata = wdata_q[sel];

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rw_d    = rw_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      lock_d  = lock_q;
      last_d  = last_q;
      for (int p = 0; p < 2; p++) begin
         ack_d[p] = 1'b0;
         err_d[p] = 2'b00;
         case (state_q[p])
            IDLE: begin
               if (multi[p]) begin
                  err_d[p]   = 2'b11;
                  ack_d[p]   = 1'b1;
                  state_d[p] = RESP;
               end else if (p_en[p]) begin
                  addr_d[p]  = in_addr[p];
                  rw_d[p]    = p_rw[p];
                  state_d[p] = p_rw[p] ? WDATA : REQ;
               end else if (p_hold[p]) begin
                  ack_d[p]   = 1'b1;
                  state_d[p] = RESP;
                  if (hold_tie) begin
                     if ((p == 0) ? last_q : !last_q) begin
                        lock_d[in_addr[p]] = own_code(p);
                        last_d             = 1'(p);
                     end else begin
                        err_d[p] = 2'b01;
                     end
                  end else if ((lock_q[in_addr[p]] == FREE) ||
                               (lock_q[in_addr[p]] == own_code(p))) begin
                     lock_d[in_addr[p]] = own_code(p);
                  end else begin
                     err_d[p] = 2'b01;
                  end
               end else if (p_rel[p]) begin
                  ack_d[p]   = 1'b1;
                  state_d[p] = RESP;
                  if (lock_q[in_addr[p]] == own_code(p)) begin
                     lock_d[in_addr[p]] = FREE;
                  end else begin
                     err_d[p] = 2'b10;
                  end
               end
            end
            WDATA: begin
               wdata_d[p] = p_ad[p];
               state_d[p] = REQ;
            end
            REQ: begin
               if (!acc_ok[p]) begin
                  err_d[p]   = 2'b01;
                  ack_d[p]   = 1'b1;
                  state_d[p] = RESP;
               end else if (grant[p]) begin
                  if (!rw_q[p]) rdata_d[p] = mem_rdata;
                  last_d     = 1'(p);
                  ack_d[p]   = 1'b1;
                  state_d[p] = RESP;
               end
            end
            default: state_d[p] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int p = 0; p < 2; p++) begin
            state_q[p] <= IDLE;
            addr_q[p]  <= '0;
            rw_q[p]    <= 1'b0;
            wdata_q[p] <= '0;
            rdata_q[p] <= '0;
            ack_q[p]   <= 1'b0;
            err_q[p]   <= 2'b00;
         end
         for (int i = 0; i < NUM_REGS; i++) lock_q[i] <= FREE;
         last_q <= 1'b1;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rw_q    <= rw_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         lock_q  <= lock_d;
         last_q  <= last_d;
      end
   end

   assign port_a.ack      = ack_q[0];
   assign port_a.err      = err_q[0];
   assign port_a.out_data = rdata_q[0];
   assign port_b.ack      = ack_q[1];
   assign port_b.err      = err_q[1];
   assign port_b.out_data = rdata_q[1];
endmodule

// File: tb/tb_csm_port_arbiter.sv
// Randomized bench: whole-transaction reference model of both ports, the lock
// table and the shared memory, compared against the arbiter per round.
module tb_csm_port_arbiter;
   localparam int OP_NONE = 0, OP_RD = 1, OP_WR = 2, OP_HOLD = 3, OP_REL = 4, OP_BAD = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic       mem_en, mem_we;
   logic [1:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata;
   logic [7:0] tb_mem [4] = '{8'h00, 8'h11, 8'h22, 8'h33};

   csm_port_if #(.DATA_W(8)) pa ();
   csm_port_if #(.DATA_W(8)) pb ();

   csm_port_arbiter #(.NUM_REGS(4), .ADDR_W(2), .DATA_W(8)) dut (
      .clk(clk), .reset(reset), .port_a(pa), .port_b(pb),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

   always #5 clk = ~clk;

   assign mem_rdata = tb_mem[mem_addr];
   always @(posedge clk) if (mem_en && mem_we) tb_mem[mem_addr] <= mem_wdata;

   int total = 0, bad = 0;

   // Reference state: memory image, lock owners (0 free, 1 A, 2 B), last grant.
   int m_mem [4] = '{8'h00, 8'h11, 8'h22, 8'h33};
   int m_lock [4] = '{0, 0, 0, 0};
   int m_last = 1;
   int m_out [2] = '{0, 0};

   int op [2], addr [2], data [2];
   int exp_err [2], exp_lat [2], exp_grants;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int mem_image();
      return {tb_mem[3], tb_mem[2], tb_mem[1], tb_mem[0]};
   endfunction

   function automatic int model_image();
      return (m_mem[3] << 24) | (m_mem[2] << 16) | (m_mem[1] << 8) | m_mem[0];
   endfunction

   // Lock requests resolve against the lock table as it was when the round
   // started; accesses (REQ one or two cycles later) see the result of them.
   task automatic model_round();
      int lk0 [4];
      int gc [2];
      bit acc [2];
      int w;
      for (int i = 0; i < 4; i++) lk0[i] = m_lock[i];
      exp_grants = 0;
      for (int p = 0; p < 2; p++) begin
         gc[p] = 0; acc[p] = 0; exp_err[p] = 0; exp_lat[p] = 0;
         case (op[p])
            OP_BAD:  begin exp_err[p] = 3; exp_lat[p] = 1; end
            OP_HOLD: begin
               exp_lat[p] = 1;
               if (lk0[addr[p]] == 0 || lk0[addr[p]] == p + 1) m_lock[addr[p]] = p + 1;
               else exp_err[p] = 1;
            end
            OP_REL:  begin
               exp_lat[p] = 1;
               if (lk0[addr[p]] == p + 1) m_lock[addr[p]] = 0;
               else exp_err[p] = 2;
            end
            default: ;
         endcase
      end
      if (op[0] == OP_HOLD && op[1] == OP_HOLD && addr[0] == addr[1] && lk0[addr[0]] == 0) begin
         w = (m_last == 1) ? 0 : 1;
         m_lock[addr[0]] = w + 1;
         exp_err[w] = 0;
         exp_err[1 - w] = 1;
         m_last = w;
      end
      for (int p = 0; p < 2; p++) begin
         if (op[p] == OP_RD || op[p] == OP_WR) begin
            int base = (op[p] == OP_RD) ? 1 : 2;
            if (m_lock[addr[p]] != 0 && m_lock[addr[p]] != p + 1) begin
               exp_err[p] = 1;
               exp_lat[p] = base + 1;
            end else begin
               acc[p] = 1;
               gc[p] = base;
            end
         end
      end
      if (acc[0] && acc[1] && gc[0] == gc[1]) begin
         w = (m_last == 1) ? 0 : 1;
         gc[1 - w]++;
      end
      for (int c = 1; c <= 3; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (acc[p] && gc[p] == c) begin
               if (op[p] == OP_RD) m_out[p] = m_mem[addr[p]];
               else m_mem[addr[p]] = data[p];
               m_last = p;
               exp_lat[p] = c + 1;
               exp_grants++;
            end
         end
      end
   endtask

   task automatic set_port(input int p, input logic [7:0] ad, input logic rw,
                           input logic en, input logic hold, input logic rel);
      if (p == 0) begin
         pa.in_ad = ad; pa.rw = rw; pa.enable = en; pa.hold = hold; pa.release_lock = rel;
      end else begin
         pb.in_ad = ad; pb.rw = rw; pb.enable = en; pb.hold = hold; pb.release_lock = rel;
      end
   endtask

   task automatic drive_first(input int p);
      logic [7:0] ad;
      ad = {6'($urandom), 2'(addr[p])};
      case (op[p])
         OP_RD:   set_port(p, ad, 1'b0, 1'b1, 1'b0, 1'b0);
         OP_WR:   set_port(p, ad, 1'b1, 1'b1, 1'b0, 1'b0);
         OP_HOLD: set_port(p, ad, 1'($urandom), 1'b0, 1'b1, 1'b0);
         OP_REL:  set_port(p, ad, 1'($urandom), 1'b0, 1'b0, 1'b1);
         OP_BAD:  set_port(p, ad, 1'($urandom), 1'b1, 1'b1, 1'($urandom));
         default: set_port(p, 8'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
      endcase
   endtask

   task automatic do_round(input int opa, input int aa, input int da,
                           input int opb, input int ab, input int db);
      int ack_cyc [2], ack_n [2], got_err [2], stray [2];
      int men;
      string nm;
      logic a, e1, e2;
      op[0] = opa; addr[0] = aa; data[0] = da;
      op[1] = opb; addr[1] = ab; data[1] = db;
      model_round();
      @(negedge clk);
      drive_first(0);
      drive_first(1);
      men = 0;
      for (int p = 0; p < 2; p++) begin ack_cyc[p] = 0; ack_n[p] = 0; got_err[p] = 0; stray[p] = 0; end
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (mem_en) men++;
         for (int p = 0; p < 2; p++) begin
            a  = (p == 0) ? pa.ack : pb.ack;
            e1 = (p == 0) ? pa.err[1] : pb.err[1];
            e2 = (p == 0) ? pa.err[0] : pb.err[0];
            if (a) begin
               ack_n[p]++;
               if (ack_cyc[p] == 0) begin ack_cyc[p] = c; got_err[p] = {e1, e2}; end
            end else if (e1 || e2) begin
               stray[p]++;
            end
         end
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            if (c == 1 && op[p] == OP_WR) set_port(p, 8'(data[p]), 1'b0, 1'b0, 1'b0, 1'b0);
            else set_port(p, 8'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
         end
      end
      for (int p = 0; p < 2; p++) begin
         nm = (p == 0) ? "a" : "b";
         chk({nm, "_ack_cycle"}, ack_cyc[p], exp_lat[p]);
         chk({nm, "_ack_count"}, ack_n[p], (op[p] == OP_NONE) ? 0 : 1);
         if (op[p] != OP_NONE) chk({nm, "_err"}, got_err[p], exp_err[p]);
         chk({nm, "_err_idle"}, stray[p], 0);
         chk({nm, "_out_data"}, (p == 0) ? int'(pa.out_data) : int'(pb.out_data), m_out[p]);
      end
      chk("mem_en_cycles", men, exp_grants);
      chk("mem_image", mem_image(), model_image());
   endtask

   task automatic rand_op(output int o);
      int r = $urandom_range(0, 9);
      if (r == 0) o = OP_NONE;
      else if (r <= 3) o = OP_RD;
      else if (r <= 6) o = OP_WR;
      else if (r == 7) o = OP_HOLD;
      else if (r == 8) o = OP_REL;
      else o = OP_BAD;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int oa, ob, rsta;
      set_port(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      set_port(1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_ack", pa.ack, 0);
      chk("rst_a_err", pa.err, 0);
      chk("rst_b_out", pb.out_data, 0);
      chk("rst_mem_en", mem_en, 0);
      @(negedge clk);
      reset = 1'b0;

      // Directed sequences
      do_round(OP_RD, 1, 0, OP_RD, 3, 0);
      do_round(OP_RD, 2, 0, OP_RD, 0, 0);
      do_round(OP_WR, 2, 8'hA5, OP_NONE, 0, 0);
      do_round(OP_RD, 2, 0, OP_NONE, 0, 0);
      do_round(OP_HOLD, 1, 0, OP_NONE, 0, 0);
      do_round(OP_NONE, 0, 0, OP_WR, 1, 8'h77);
      do_round(OP_WR, 1, 8'h44, OP_NONE, 0, 0);
      do_round(OP_REL, 1, 0, OP_NONE, 0, 0);
      do_round(OP_NONE, 0, 0, OP_WR, 1, 8'h77);
      do_round(OP_NONE, 0, 0, OP_RD, 1, 0);
      do_round(OP_NONE, 0, 0, OP_REL, 0, 0);
      do_round(OP_BAD, 2, 0, OP_NONE, 0, 0);
      do_round(OP_RD, 0, 0, OP_NONE, 0, 0);
      do_round(OP_HOLD, 3, 0, OP_HOLD, 3, 0);
      do_round(OP_WR, 3, 8'h5C, OP_WR, 3, 8'hC5);
      do_round(OP_NONE, 0, 0, OP_REL, 3, 0);

      for (int i = 0; i < 250; i++) begin
         rand_op(oa);
         rand_op(ob);
         do_round(oa, $urandom_range(0, 3), $urandom_range(0, 255),
                  ob, $urandom_range(0, 3), $urandom_range(0, 255));
      end

      // Reset while A sits in WDATA with a lock held
      do_round(OP_HOLD, 0, 0, OP_NONE, 0, 0);
      @(negedge clk);
      set_port(0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      set_port(0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_a_ack", pa.ack, 0);
      chk("rst_mid_a_out", pa.out_data, 0);
      chk("rst_mid_b_out", pb.out_data, 0);
      chk("rst_mid_mem_en", mem_en, 0);
      @(negedge clk);
      reset = 1'b0;
      rsta = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (pa.ack) rsta++;
      end
      chk("rst_mid_no_ack", rsta, 0);
      chk("rst_mid_mem", mem_image(), model_image());
      for (int i = 0; i < 4; i++) m_lock[i] = 0;
      m_last = 1;
      m_out[0] = 0;
      m_out[1] = 0;
      do_round(OP_NONE, 0, 0, OP_WR, 0, 8'h99);
      do_round(OP_RD, 0, 0, OP_RD, 2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
